ecc_line_scrubber: RTL and testbench
====================================

// Module: ecc_line_scrubber
// PURPOSE
//  Registered ECC check/correct stage for SRAM cache-line reads with write-back scrubbing.
//  Decodes all ways of a set (data per division + tag), returns corrected lines with per-way error status,
//  then issues corrected-line write-backs for ways with single-bit errors.
//  Maintains saturating error counters. Sits between the cache SRAM read port and the cache controller.
// PARAMETERS
//  ASSOC        4    number of ways per set
//  DIVISIONS    4    ECC blocks per data line
//  DATA_WIDTH   128  unencoded data bits per line; BLK = DATA_WIDTH/DIVISIONS
//  TAG_WIDTH    44   unencoded tag bits
//  INDEX_WIDTH  8    set index width
//  CNT_WIDTH    16   error counter width
//  SCRUB_EN     1    1: write-back scrubbing enabled; 0: SCRUB state never entered
//  derived: BLK_ECC = BLK+$clog2(BLK)+2; TAG_ECC = TAG_WIDTH+$clog2(TAG_WIDTH)+2;
//           LINE_W = 2+TAG_ECC+DIVISIONS*BLK_ECC; way layout {valid, dirty, tag_ecc, data_ecc}, division j at data_ecc[j*BLK_ECC +: BLK_ECC]
// PORTS
//  clk_i           in   1               clock
//  rst_i           in   1               synchronous reset, active high
//  req_valid_i     in   1               set read data valid
//  req_ready_o     out  1               stage can accept a set
//  req_index_i     in   INDEX_WIDTH     set index
//  req_lines_i     in   ASSOC*LINE_W    encoded ways as read from SRAM
//  rsp_valid_o     out  1               corrected set valid
//  rsp_ready_i     in   1               consumer accepts set
//  rsp_index_o     out  INDEX_WIDTH     captured index
//  rsp_lines_o     out  ASSOC*LINE_W    corrected encoded ways
//  rsp_err_o       out  ASSOC*2         per way: [0] correctable, [1] uncorrectable
//  scrub_valid_o   out  1               write-back request valid
//  scrub_ready_i   in   1               write-back accepted
//  scrub_way_o     out  $clog2(ASSOC)   way to rewrite (width 1 when ASSOC=1)
//  scrub_index_o   out  INDEX_WIDTH     set to rewrite
//  scrub_line_o    out  LINE_W          corrected encoded line
//  clear_cnt_i     in   1               clear both counters
//  corr_cnt_o      out  CNT_WIDTH       sets with >=1 correctable-only way
//  uncorr_cnt_o    out  CNT_WIDTH       sets with >=1 uncorrectable way
// BEHAVIOUR
//  Decode: one hsiao_ecc_cor per division per way plus one per tag; valid/dirty pass through unchanged.
//   way err[1] = valid & OR(all err[1]); err[0] = valid & OR(all err[0]) & ~err[1]. Invalid way: err = 2'b00.
//  FSM IDLE/RESP/SCRUB; reset -> IDLE, all valids 0, counters 0, scrub mask 0, data regs 0.
//  IDLE: req_ready_o=1; on req_valid_i capture corrected lines, err, index, scrub mask = {err[i][0]} -> RESP.
//  RESP: rsp_valid_o=1, outputs stable until rsp_ready_i; on handshake -> SCRUB if SCRUB_EN && mask!=0, else IDLE.
//  SCRUB: scrub_valid_o=1 for lowest set mask bit; way/index/line stable until scrub_ready_i;
//   on handshake clear that bit; mask becomes 0 -> IDLE. Uncorrectable ways are never scrubbed.
//  req_ready_o=0 outside IDLE; latency req accept -> rsp_valid_o = 1 cycle; no back-to-back accept.
//  Counters: on capture, corr +1 if any way err[0], uncorr +1 if any way err[1] (both can increment);
//   saturate at all-ones; clear_cnt_i same cycle as increment -> 0 (clear wins).
//  Reset mid-RESP/SCRUB: pending response and write-backs dropped, no valid pulses after reset cycle.
// TESTING
//  ASSOC=2,DIVISIONS=2,DATA_WIDTH=64,TAG_WIDTH=20: clean set -> rsp 1 cycle later, err=0, no scrub, counters 0.
//  Flip bit 5 of way1 div0 -> rsp_lines way1 equals clean codeword, err way1=2'b01, scrub_way_o=1, corr_cnt=1.
//  Flip 2 bits of way0 tag, 1 bit of way1 data -> err={01,10}, only way1 scrubbed, corr=1, uncorr=1.
//  Single-bit errors in both ways, scrub_ready_i low 3 cycles -> way0 held stable, then way1, then IDLE.
//  Errors in an invalid way -> err=0, no scrub; rsp_ready_i held low 5 cycles -> outputs stable.
//  CNT_WIDTH=2: 4 corrected sets -> corr_cnt=3; clear with increment -> 0; rst_i during SCRUB -> scrub_valid_o=0 next cycle.

Source files
------------

// File: rtl/ecc_line_scrubber_if.sv
// Bus bundle for the ECC line scrubber. It carries the SRAM read-side request,
// the corrected response to the controller, and the scrub write-back request.
interface ecc_line_scrubber_if #(
  parameter int ASSOC       = 4,
  parameter int INDEX_WIDTH = 8,
  parameter int LINE_W      = 210,
  parameter int WAY_W       = 2
);
  logic                      req_valid_i;
  logic                      req_ready_o;
  logic [INDEX_WIDTH-1:0]    req_index_i;
  logic [ASSOC*LINE_W-1:0]   req_lines_i;
  logic                      rsp_valid_o;
  logic                      rsp_ready_i;
  logic [INDEX_WIDTH-1:0]    rsp_index_o;
  logic [ASSOC*LINE_W-1:0]   rsp_lines_o;
  logic [ASSOC*2-1:0]        rsp_err_o;
  logic                      scrub_valid_o;
  logic                      scrub_ready_i;
  logic [WAY_W-1:0]          scrub_way_o;
  logic [INDEX_WIDTH-1:0]    scrub_index_o;
  logic [LINE_W-1:0]         scrub_line_o;

  modport slave (
    input  req_valid_i, req_index_i, req_lines_i, rsp_ready_i, scrub_ready_i,
    output req_ready_o, rsp_valid_o, rsp_index_o, rsp_lines_o, rsp_err_o,
           scrub_valid_o, scrub_way_o, scrub_index_o, scrub_line_o
  );

  modport master (
    output req_valid_i, req_index_i, req_lines_i, rsp_ready_i, scrub_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_index_o, rsp_lines_o, rsp_err_o,
           scrub_valid_o, scrub_way_o, scrub_index_o, scrub_line_o
  );
endinterface

// File: rtl/ecc_line_scrubber.sv
// Registered Hsiao SEC-DED check/correct stage for a full cache set, with
// write-back scrubbing of single-bit-error ways and saturating error counters.

// Codeword = {check[R-1:0], data[K-1:0]}. Data column i is the i-th odd-weight
// (>=3) R-bit value in ascending order; check bit j has the one-hot column.
module hsiao_ecc_cor #(
  parameter int K = 32,
  localparam int R = $clog2(K) + 2
) (
  input  logic [K+R-1:0] cw_i,
  output logic [K+R-1:0] cw_o,
  output logic [1:0]     err_o
);
  function automatic logic [K*R-1:0] gen_h();
    logic [K*R-1:0] h;
    logic [R-1:0]   w;
    int             n;
    h = '0;
    n = 0;
    for (int v = 1; v < (1 << R); v++) begin
      w = v[R-1:0];
      if (($countones(w) >= 3) && (($countones(w) % 2) == 1) && (n < K)) begin
        h[n*R +: R] = w;
        n++;
      end
    end
    return h;
  endfunction

  localparam logic [K*R-1:0] H = gen_h();

  logic [R-1:0] syn;
  logic         hit;

  always_comb begin
    syn   = cw_i[K +: R];
    cw_o  = cw_i;
    err_o = 2'b00;
    hit   = 1'b0;
    for (int i = 0; i < K; i++) begin
      if (cw_i[i]) syn = syn ^ H[i*R +: R];
    end
    if (syn != '0) begin
      if (($countones(syn) % 2) == 0) begin
        err_o = 2'b10;
      end else begin
        for (int i = 0; i < K; i++) begin
          if (syn == H[i*R +: R]) begin
            cw_o[i] = ~cw_i[i];
            hit     = 1'b1;
          end
        end
        // A weight-1 syndrome points at a flipped check bit.
        if ($countones(syn) == 1) begin
          cw_o[K +: R] = cw_i[K +: R] ^ syn;
          hit          = 1'b1;
        end
        err_o = hit ? 2'b01 : 2'b10;
      end
    end
  end
endmodule

module ecc_line_scrubber #(
  parameter int ASSOC       = 4,
  parameter int DIVISIONS   = 4,
  parameter int DATA_WIDTH  = 128,
  parameter int TAG_WIDTH   = 44,
  parameter int INDEX_WIDTH = 8,
  parameter int CNT_WIDTH   = 16,
  parameter int SCRUB_EN    = 1,
  localparam int BLK     = DATA_WIDTH / DIVISIONS,
  localparam int BLK_ECC = BLK + $clog2(BLK) + 2,
  localparam int TAG_ECC = TAG_WIDTH + $clog2(TAG_WIDTH) + 2,
  localparam int LINE_W  = 2 + TAG_ECC + DIVISIONS * BLK_ECC,
  localparam int WAY_W   = (ASSOC > 1) ? $clog2(ASSOC) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  ecc_line_scrubber_if.slave   bus,
  input  logic                 clear_cnt_i,
  output logic [CNT_WIDTH-1:0] corr_cnt_o,
  output logic [CNT_WIDTH-1:0] uncorr_cnt_o
);
  typedef enum logic [1:0] {IDLE, RESP, SCRUB} state_t;

  logic [ASSOC*LINE_W-1:0] dec_lines;
  logic [ASSOC*2-1:0]      dec_err;

  for (genvar gi = 0; gi < ASSOC; gi++) begin : g_way
    logic [DIVISIONS:0] e0;
    logic [DIVISIONS:0] e1;
    logic               way_valid;

    assign way_valid = bus.req_lines_i[gi*LINE_W + LINE_W - 1];

    for (genvar gj = 0; gj < DIVISIONS; gj++) begin : g_div
      hsiao_ecc_cor #(.K(BLK)) u_blk (
        .cw_i  (bus.req_lines_i[gi*LINE_W + gj*BLK_ECC +: BLK_ECC]),
        .cw_o  (dec_lines[gi*LINE_W + gj*BLK_ECC +: BLK_ECC]),
        .err_o ({e1[gj], e0[gj]})
      );
    end

    hsiao_ecc_cor #(.K(TAG_WIDTH)) u_tag (
      .cw_i  (bus.req_lines_i[gi*LINE_W + DIVISIONS*BLK_ECC +: TAG_ECC]),
      .cw_o  (dec_lines[gi*LINE_W + DIVISIONS*BLK_ECC +: TAG_ECC]),
      .err_o ({e1[DIVISIONS], e0[DIVISIONS]})
    );

    assign dec_lines[gi*LINE_W + LINE_W - 2 +: 2] = bus.req_lines_i[gi*LINE_W + LINE_W - 2 +: 2];
    assign dec_err[gi*2 + 1] = way_valid & (|e1);
    assign dec_err[gi*2]     = way_valid & (|e0) & ~(|e1);
  end

  state_t                  state_q, state_d;
  logic [ASSOC*LINE_W-1:0] lines_q, lines_d;
  logic [ASSOC*2-1:0]      err_q, err_d;
  logic [INDEX_WIDTH-1:0]  index_q, index_d;
  logic [ASSOC-1:0]        mask_q, mask_d;
  logic [CNT_WIDTH-1:0]    corr_cnt_q, corr_cnt_d;
  logic [CNT_WIDTH-1:0]    uncorr_cnt_q, uncorr_cnt_d;
  logic [WAY_W-1:0]        sel_way;
  logic                    any_corr, any_uncorr;

  always_comb begin
    sel_way = '0;
    for (int i = ASSOC - 1; i >= 0; i--) begin
      if (mask_q[i]) sel_way = WAY_W'(i);
    end
  end

  always_comb begin
    any_corr   = 1'b0;
    any_uncorr = 1'b0;
    for (int i = 0; i < ASSOC; i++) begin
      any_corr   = any_corr | dec_err[2*i];
      any_uncorr = any_uncorr | dec_err[2*i + 1];
    end
  end

  always_comb begin
    state_d      = state_q;
    lines_d      = lines_q;
    err_d        = err_q;
    index_d      = index_q;
    mask_d       = mask_q;
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          lines_d = dec_lines;
          err_d   = dec_err;
          index_d = bus.req_index_i;
          for (int i = 0; i < ASSOC; i++) mask_d[i] = dec_err[2*i];
          if (any_corr && !(&corr_cnt_q))     corr_cnt_d   = corr_cnt_q + CNT_WIDTH'(1);
          if (any_uncorr && !(&uncorr_cnt_q)) uncorr_cnt_d = uncorr_cnt_q + CNT_WIDTH'(1);
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          state_d = ((SCRUB_EN != 0) && (mask_q != '0)) ? SCRUB : IDLE;
        end
      end
      SCRUB: begin
        if (bus.scrub_ready_i) begin
          mask_d[sel_way] = 1'b0;
          if (mask_d == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Clearing takes priority over a same-cycle increment.
    if (clear_cnt_i) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      lines_q      <= '0;
      err_q        <= '0;
      index_q      <= '0;
      mask_q       <= '0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      lines_q      <= lines_d;
      err_q        <= err_d;
      index_q      <= index_d;
      mask_q       <= mask_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign bus.req_ready_o   = (state_q == IDLE);
  assign bus.rsp_valid_o   = (state_q == RESP);
  assign bus.rsp_index_o   = index_q;
  assign bus.rsp_lines_o   = lines_q;
  assign bus.rsp_err_o     = err_q;
  assign bus.scrub_valid_o = (state_q == SCRUB);
  assign bus.scrub_way_o   = sel_way;
  assign bus.scrub_index_o = index_q;
  assign bus.scrub_line_o  = lines_q[sel_way*LINE_W +: LINE_W];
  assign corr_cnt_o        = corr_cnt_q;
  assign uncorr_cnt_o      = uncorr_cnt_q;
endmodule

// File: tb/tb_ecc_line_scrubber.sv
// Directed bench for ecc_line_scrubber: 2 ways, 2 divisions of 32 bits, 20-bit
// tag, 2-bit counters; codewords are built by an independent Hsiao encoder.
module tb_ecc_line_scrubber;
  localparam int LW = 107;
  localparam int LS = 2 * LW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic [1:0] corr_cnt, uncorr_cnt;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ecc_line_scrubber_if #(.ASSOC(2), .INDEX_WIDTH(8), .LINE_W(LW), .WAY_W(1)) bus ();

  ecc_line_scrubber #(
    .ASSOC(2), .DIVISIONS(2), .DATA_WIDTH(64), .TAG_WIDTH(20),
    .INDEX_WIDTH(8), .CNT_WIDTH(2), .SCRUB_EN(1)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus          (bus.slave),
    .clear_cnt_i  (clr),
    .corr_cnt_o   (corr_cnt),
    .uncorr_cnt_o (uncorr_cnt)
  );

  function automatic logic [6:0] chk_bits(input logic [31:0] d, input int k);
    logic [6:0] c;
    logic [6:0] w;
    int n;
    c = '0;
    n = 0;
    for (int v = 1; v < 128; v++) begin
      w = v[6:0];
      if ($countones(w) >= 3 && ($countones(w) % 2) == 1) begin
        if (n < k) begin
          if (d[n]) c = c ^ w;
        end
        n++;
      end
    end
    return c;
  endfunction

  function automatic logic [LW-1:0] make_way(input logic v, input logic dt, input logic [19:0] t,
                                             input logic [31:0] d0, input logic [31:0] d1);
    return {v, dt, chk_bits({12'b0, t}, 20), t, chk_bits(d1, 32), d1, chk_bits(d0, 32), d0};
  endfunction

  task automatic send(input logic [7:0] idx, input logic [LS-1:0] lines);
    bus.req_valid_i = 1'b1;
    bus.req_index_i = idx;
    bus.req_lines_i = lines;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    $display("set idx=%h rsp_valid=%b err=%b corr=%0d uncorr=%0d",
             idx, bus.rsp_valid_o, bus.rsp_err_o, corr_cnt, uncorr_cnt);
  endtask

  task automatic rsp_handshake();
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
  endtask

  task automatic clear_counters();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.req_ready_o); end
    checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid_o); end
    checks++; if (bus.scrub_valid_o !== 1'b0) begin errors++; $display("FAIL reset_scrub_valid: got %b expected 0", bus.scrub_valid_o); end
    checks++; if (bus.rsp_lines_o !== '0) begin errors++; $display("FAIL reset_lines: got %h expected 0", bus.rsp_lines_o); end
    checks++; if ({corr_cnt, uncorr_cnt} !== 4'b0) begin errors++; $display("FAIL reset_cnt: got %b expected 0000", {corr_cnt, uncorr_cnt}); end
  endtask

  task automatic test_clean();
    logic [LS-1:0] l;
    l = {make_way(1, 1, 20'habcde, 32'h0, 32'hffffffff), make_way(1, 0, 20'h12345, 32'hdeadbeef, 32'h01234567)};
    checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL clean_ready: got %b expected 1", bus.req_ready_o); end
    send(8'h11, l);
    checks++; if (bus.rsp_valid_o !== 1'b1) begin errors++; $display("FAIL clean_latency: got %b expected 1", bus.rsp_valid_o); end
    checks++; if (bus.rsp_lines_o !== l) begin errors++; $display("FAIL clean_lines: got %h expected %h", bus.rsp_lines_o, l); end
    checks++; if (bus.rsp_err_o !== 4'b0000) begin errors++; $display("FAIL clean_err: got %b expected 0000", bus.rsp_err_o); end
    checks++; if (bus.rsp_index_o !== 8'h11) begin errors++; $display("FAIL clean_index: got %h expected 11", bus.rsp_index_o); end
    checks++; if (bus.req_ready_o !== 1'b0) begin errors++; $display("FAIL clean_busy: got %b expected 0", bus.req_ready_o); end
    rsp_handshake();
    checks++; if (bus.scrub_valid_o !== 1'b0) begin errors++; $display("FAIL clean_no_scrub: got %b expected 0", bus.scrub_valid_o); end
    checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL clean_idle: got %b expected 1", bus.req_ready_o); end
    checks++; if ({corr_cnt, uncorr_cnt} !== 4'b0) begin errors++; $display("FAIL clean_cnt: got %b expected 0000", {corr_cnt, uncorr_cnt}); end
  endtask

  task automatic test_single();
    logic [LS-1:0] clean, l;
    clean = {make_way(1, 0, 20'h0f0f0, 32'h13579bdf, 32'h2468ace0), make_way(1, 0, 20'h00001, 32'h1, 32'h2)};
    l = clean;
    l[LW + 5] = ~l[LW + 5];
    send(8'h22, l);
    checks++; if (bus.rsp_lines_o !== clean) begin errors++; $display("FAIL single_lines: got %h expected %h", bus.rsp_lines_o, clean); end
    checks++; if (bus.rsp_err_o !== 4'b0100) begin errors++; $display("FAIL single_err: got %b expected 0100", bus.rsp_err_o); end
    checks++; if (corr_cnt !== 2'd1) begin errors++; $display("FAIL single_corr_cnt: got %0d expected 1", corr_cnt); end
    rsp_handshake();
    checks++; if (bus.scrub_valid_o !== 1'b1) begin errors++; $display("FAIL single_scrub_valid: got %b expected 1", bus.scrub_valid_o); end
    checks++; if (bus.scrub_way_o !== 1'b1) begin errors++; $display("FAIL single_scrub_way: got %0d expected 1", bus.scrub_way_o); end
    checks++; if (bus.scrub_index_o !== 8'h22) begin errors++; $display("FAIL single_scrub_index: got %h expected 22", bus.scrub_index_o); end
    checks++; if (bus.scrub_line_o !== clean[LW +: LW]) begin errors++; $display("FAIL single_scrub_line: got %h expected %h", bus.scrub_line_o, clean[LW +: LW]); end
    bus.scrub_ready_i = 1'b1;
    @(negedge clk);
    bus.scrub_ready_i = 1'b0;
    $display("scrub way=1 idx=22 accepted");
    checks++; if (bus.scrub_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL single_done: got scrub_valid=%b ready=%b expected 0/1", bus.scrub_valid_o, bus.req_ready_o); end
  endtask

  task automatic test_mixed();
    logic [LS-1:0] clean, l, exp_l;
    clean = {make_way(1, 1, 20'h55555, 32'hcafef00d, 32'h0badc0de), make_way(1, 0, 20'haaaaa, 32'h87654321, 32'h11111111)};
    l = clean;
    l[78 + 2]       = ~l[78 + 2];
    l[78 + 10]      = ~l[78 + 10];
    l[LW + 39 + 3]  = ~l[LW + 39 + 3];
    exp_l = {clean[LW +: LW], l[0 +: LW]};
    clear_counters();
    send(8'h33, l);
    checks++; if (bus.rsp_err_o !== 4'b0110) begin errors++; $display("FAIL mixed_err: got %b expected 0110", bus.rsp_err_o); end
    checks++; if (bus.rsp_lines_o !== exp_l) begin errors++; $display("FAIL mixed_lines: got %h expected %h", bus.rsp_lines_o, exp_l); end
    checks++; if (corr_cnt !== 2'd1 || uncorr_cnt !== 2'd1) begin errors++; $display("FAIL mixed_cnt: got corr=%0d uncorr=%0d expected 1/1", corr_cnt, uncorr_cnt); end
    rsp_handshake();
    checks++; if (bus.scrub_valid_o !== 1'b1 || bus.scrub_way_o !== 1'b1) begin errors++; $display("FAIL mixed_scrub: got valid=%b way=%0d expected 1/1", bus.scrub_valid_o, bus.scrub_way_o); end
    bus.scrub_ready_i = 1'b1;
    @(negedge clk);
    bus.scrub_ready_i = 1'b0;
    $display("scrub way=1 idx=33 accepted");
    checks++; if (bus.scrub_valid_o !== 1'b0) begin errors++; $display("FAIL mixed_only_way1: got %b expected 0", bus.scrub_valid_o); end
  endtask

  task automatic test_back_to_back();
    logic [LS-1:0] clean, l;
    clean = {make_way(1, 0, 20'h3c3c3, 32'h00ff00ff, 32'hff00ff00), make_way(1, 1, 20'hc3c3c, 32'h12121212, 32'h34343434)};
    l = clean;
    l[39]            = ~l[39];
    l[LW + 78 + 22]  = ~l[LW + 78 + 22];
    send(8'h44, l);
    bus.req_valid_i = 1'b1;
    checks++; if (bus.req_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_no_accept: got %b expected 0", bus.req_ready_o); end
    checks++; if (bus.rsp_err_o !== 4'b0101) begin errors++; $display("FAIL b2b_err: got %b expected 0101", bus.rsp_err_o); end
    checks++; if (bus.rsp_lines_o !== clean) begin errors++; $display("FAIL b2b_lines: got %h expected %h", bus.rsp_lines_o, clean); end
    rsp_handshake();
    bus.req_valid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.scrub_valid_o !== 1'b1 || bus.scrub_way_o !== 1'b0 || bus.scrub_line_o !== clean[0 +: LW] || bus.req_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL b2b_hold_way0 cycle %0d: got valid=%b way=%0d ready=%b line=%h expected 1/0/0 line=%h",
                 c, bus.scrub_valid_o, bus.scrub_way_o, bus.req_ready_o, bus.scrub_line_o, clean[0 +: LW]);
      end
      @(negedge clk);
    end
    bus.scrub_ready_i = 1'b1;
    @(negedge clk);
    $display("scrub way=0 idx=44 accepted");
    checks++; if (bus.scrub_valid_o !== 1'b1 || bus.scrub_way_o !== 1'b1 || bus.scrub_line_o !== clean[LW +: LW]) begin errors++; $display("FAIL b2b_way1: got valid=%b way=%0d line=%h expected 1/1 line=%h", bus.scrub_valid_o, bus.scrub_way_o, bus.scrub_line_o, clean[LW +: LW]); end
    @(negedge clk);
    bus.scrub_ready_i = 1'b0;
    $display("scrub way=1 idx=44 accepted");
    checks++; if (bus.scrub_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_idle: got valid=%b ready=%b expected 0/1", bus.scrub_valid_o, bus.req_ready_o); end
  endtask

  task automatic test_invalid_way();
    logic [LS-1:0] clean, l;
    clean = {make_way(1, 1, 20'h77777, 32'h89abcdef, 32'hfedcba98), make_way(0, 0, 20'h00000, 32'h0, 32'h0)};
    l = clean;
    l[4]      = ~l[4];
    l[78 + 1] = ~l[78 + 1];
    l[78 + 7] = ~l[78 + 7];
    clear_counters();
    send(8'h55, l);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_err_o !== 4'b0000 || bus.rsp_index_o !== 8'h55 || bus.rsp_lines_o[LW +: LW] !== clean[LW +: LW]) begin
        errors++;
        $display("FAIL invalid_hold cycle %0d: got valid=%b err=%b idx=%h expected 1/0000/55", c, bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_index_o);
      end
      @(negedge clk);
    end
    rsp_handshake();
    checks++; if (bus.scrub_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL invalid_no_scrub: got valid=%b ready=%b expected 0/1", bus.scrub_valid_o, bus.req_ready_o); end
    checks++; if ({corr_cnt, uncorr_cnt} !== 4'b0) begin errors++; $display("FAIL invalid_cnt: got %b expected 0000", {corr_cnt, uncorr_cnt}); end
  endtask

  task automatic test_counters();
    logic [LS-1:0] l;
    logic [1:0] exp_c;
    l = {make_way(1, 0, 20'h1, 32'h2, 32'h3), make_way(1, 0, 20'h4, 32'h5, 32'h6)};
    l[10] = ~l[10];
    clear_counters();
    for (int n = 1; n <= 4; n++) begin
      send(8'h60 + 8'(n), l);
      exp_c = (n > 3) ? 2'd3 : 2'(n);
      checks++; if (corr_cnt !== exp_c) begin errors++; $display("FAIL cnt_sat set %0d: got %0d expected %0d", n, corr_cnt, exp_c); end
      rsp_handshake();
      bus.scrub_ready_i = 1'b1;
      @(negedge clk);
      bus.scrub_ready_i = 1'b0;
    end
    clr = 1'b1;
    send(8'h6f, l);
    clr = 1'b0;
    checks++; if (corr_cnt !== 2'd0 || uncorr_cnt !== 2'd0) begin errors++; $display("FAIL cnt_clear_wins: got corr=%0d uncorr=%0d expected 0/0", corr_cnt, uncorr_cnt); end
    rsp_handshake();
    bus.scrub_ready_i = 1'b1;
    @(negedge clk);
    bus.scrub_ready_i = 1'b0;
  endtask

  task automatic test_reset_scrub();
    logic [LS-1:0] l;
    l = {make_way(1, 0, 20'h9, 32'h8, 32'h7), make_way(1, 0, 20'h6, 32'h5, 32'h4)};
    l[LW + 20] = ~l[LW + 20];
    send(8'h77, l);
    rsp_handshake();
    checks++; if (bus.scrub_valid_o !== 1'b1) begin errors++; $display("FAIL rst_scrub_pre: got %b expected 1", bus.scrub_valid_o); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.scrub_valid_o !== 1'b0 || bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_scrub_drop: got scrub=%b rsp=%b ready=%b expected 0/0/1", bus.scrub_valid_o, bus.rsp_valid_o, bus.req_ready_o); end
    checks++; if (corr_cnt !== 2'd0) begin errors++; $display("FAIL rst_scrub_cnt: got %0d expected 0", corr_cnt); end
    @(negedge clk);
    checks++; if (bus.scrub_valid_o !== 1'b0) begin errors++; $display("FAIL rst_scrub_after: got %b expected 0", bus.scrub_valid_o); end
  endtask

  initial begin
    bus.req_valid_i   = 1'b0;
    bus.req_index_i   = '0;
    bus.req_lines_i   = '0;
    bus.rsp_ready_i   = 1'b0;
    bus.scrub_ready_i = 1'b0;
    test_reset();
    test_clean();
    test_single();
    test_mixed();
    test_back_to_back();
    test_invalid_way();
    test_counters();
    test_reset_scrub();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
